pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register for the pipelined RISC-V core. It replaces fixed-width stage latches (IF/ID, ID/EX, ...) with a valid/ready handshake and optional 2-entry skid buffering.
- Supports flush with bubble insertion, stall by backpressure, and a saturating count of squashed entries.
- Placed between any two pipeline stages. The payload is an opaque DATA_W bus, e.g. {pc, instr}.

---
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, optional skid entry,
// flush with bubble insertion and a saturating count of squashed entries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no entry held, out_data = BUBBLE
// ST_BUSY  | main entry valid on out_data, skid empty
// ST_FULL  | main and skid both valid, in_ready low (SKID=1 only)
module pipe_stage_reg #(
   parameter int                DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter bit                SKID   = 1'b1,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W+1:0] DROP_MAX = {2'b00, {CNT_W{1'b1}}};

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                in_ready_q, in_ready_d;
   logic [CNT_W-1:0]    drop_q, drop_d;
   logic                in_fire, out_fire;
   logic [2:0]          drop_add;
   logic [CNT_W+1:0]    drop_sum;

   // Handshake: SKID=1 uses the registered ready so out_ready never reaches in_ready.
   always_comb begin
      out_valid  = (state_q != ST_EMPTY);
      in_ready   = SKID ? in_ready_q : (!out_valid || out_ready);
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
      out_data   = main_q;
      occupancy  = state_q;
      drop_count = drop_q;
   end

   // Next-state, entry movement and flush accounting; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      drop_d   = drop_q;
      // entries lost = held entries not leaving downstream plus an accepted incoming beat
      drop_add = {1'b0, state_q} - {2'b00, out_fire} + {2'b00, in_fire};
      drop_sum = {2'b00, drop_q} + {{(CNT_W-1){1'b0}}, drop_add};

      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire && SKID) begin
               skid_d  = in_data;
               state_d = ST_FULL;
            end else if (out_fire) begin
               main_d  = BUBBLE;
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               skid_d  = BUBBLE;
               state_d = ST_BUSY;
            end
         end
         default: begin
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
            state_d = ST_EMPTY;
         end
      endcase

      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
         drop_d  = (drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end

      in_ready_d = (state_d != ST_FULL);
   end

   // State and payload registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance (small drop counter so it
// saturates) and one single-entry instance, directed scenarios then a
// randomized run against a queue-based reference model.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        flush1 = 0, in_valid1 = 0, out_ready1 = 0;
   logic [15:0] in_data1 = '0;
   logic        in_ready1, out_valid1;
   logic [15:0] out_data1;
   logic [1:0]  occupancy1;
   logic [3:0]  drop_count1;

   logic        flush0 = 0, in_valid0 = 0, out_ready0 = 0;
   logic [15:0] in_data0 = '0;
   logic        in_ready0, out_valid0;
   logic [15:0] out_data0;
   logic [1:0]  occupancy0;
   logic [15:0] drop_count0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .SKID(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .occupancy(occupancy1), .drop_count(drop_count1));

   pipe_stage_reg #(.DATA_W(16), .SKID(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_data(out_data0), .occupancy(occupancy0), .drop_count(drop_count0));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive1(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      in_valid1 = iv; in_data1 = d; out_ready1 = ordy; flush1 = fl;
   endtask

   task automatic drive0(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      in_valid0 = iv; in_data0 = d; out_ready0 = ordy; flush0 = fl;
   endtask

   task automatic do_reset();
      drive1(0, 16'h0, 0, 0);
      drive0(0, 16'h0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      checks += 10;
      if (out_valid1 !== 1'b0)     begin errors++; $display("FAIL reset out_valid1 got %b want 0", out_valid1); end
      if (out_data1 !== 16'h0)     begin errors++; $display("FAIL reset out_data1 got %h want 0000", out_data1); end
      if (in_ready1 !== 1'b1)      begin errors++; $display("FAIL reset in_ready1 got %b want 1", in_ready1); end
      if (occupancy1 !== 2'd0)     begin errors++; $display("FAIL reset occupancy1 got %0d want 0", occupancy1); end
      if (drop_count1 !== 4'd0)    begin errors++; $display("FAIL reset drop_count1 got %0d want 0", drop_count1); end
      if (out_valid0 !== 1'b0)     begin errors++; $display("FAIL reset out_valid0 got %b want 0", out_valid0); end
      if (out_data0 !== 16'h0)     begin errors++; $display("FAIL reset out_data0 got %h want 0000", out_data0); end
      if (in_ready0 !== 1'b1)      begin errors++; $display("FAIL reset in_ready0 got %b want 1", in_ready0); end
      if (occupancy0 !== 2'd0)     begin errors++; $display("FAIL reset occupancy0 got %0d want 0", occupancy0); end
      if (drop_count0 !== 16'd0)   begin errors++; $display("FAIL reset drop_count0 got %0d want 0", drop_count0); end
   endtask

   task automatic test_stream();
      logic [15:0] vals [3];
      vals[0] = 16'h10; vals[1] = 16'h11; vals[2] = 16'h12;
      for (int i = 0; i < 3; i++) begin
         drive1(1, vals[i], 1, 0);
         tick();
         checks += 3;
         if (out_data1 !== vals[i]) begin errors++; $display("FAIL stream data[%0d] got %h want %h", i, out_data1, vals[i]); end
         if (out_valid1 !== 1'b1)   begin errors++; $display("FAIL stream valid[%0d] got %b want 1", i, out_valid1); end
         if (occupancy1 !== 2'd1)   begin errors++; $display("FAIL stream occ[%0d] got %0d want 1", i, occupancy1); end
      end
      drive1(0, 16'h0, 1, 0);
      tick();
      checks += 2;
      if (occupancy1 !== 2'd0) begin errors++; $display("FAIL stream drain occ got %0d want 0", occupancy1); end
      if (out_data1 !== 16'h0) begin errors++; $display("FAIL stream drain data got %h want 0000", out_data1); end
   endtask

   task automatic test_backpressure();
      drive1(1, 16'hA, 0, 0);
      tick();
      checks += 2;
      if (out_data1 !== 16'hA || occupancy1 !== 2'd1) begin errors++; $display("FAIL bp first got data %h occ %0d want 000a occ 1", out_data1, occupancy1); end
      if (in_ready1 !== 1'b1) begin errors++; $display("FAIL bp ready after A got %b want 1", in_ready1); end
      drive1(1, 16'hB, 0, 0);
      tick();
      checks += 2;
      if (occupancy1 !== 2'd2) begin errors++; $display("FAIL bp occ after B got %0d want 2", occupancy1); end
      if (in_ready1 !== 1'b0)  begin errors++; $display("FAIL bp ready after B got %b want 0", in_ready1); end
      drive1(1, 16'hC, 0, 0);
      tick();
      checks += 2;
      if (occupancy1 !== 2'd2) begin errors++; $display("FAIL bp held occ got %0d want 2", occupancy1); end
      if (out_data1 !== 16'hA) begin errors++; $display("FAIL bp held data got %h want 000a", out_data1); end
      drive1(1, 16'hC, 1, 0);
      #1;
      checks += 1;
      if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp ready comb path got %b want 0", in_ready1); end
      tick();
      checks += 2;
      if (out_data1 !== 16'hB || occupancy1 !== 2'd1) begin errors++; $display("FAIL bp drain B got data %h occ %0d want 000b occ 1", out_data1, occupancy1); end
      if (in_ready1 !== 1'b1) begin errors++; $display("FAIL bp ready after drain got %b want 1", in_ready1); end
      tick();
      checks += 1;
      if (out_data1 !== 16'hC || occupancy1 !== 2'd1) begin errors++; $display("FAIL bp drain C got data %h occ %0d want 000c occ 1", out_data1, occupancy1); end
      drive1(0, 16'h0, 1, 0);
      tick();
      checks += 1;
      if (out_valid1 !== 1'b0) begin errors++; $display("FAIL bp empty valid got %b want 0", out_valid1); end
   endtask

   task automatic test_flush_full();
      drive1(1, 16'hA, 0, 0); tick();
      drive1(1, 16'hB, 0, 0); tick();
      checks += 1;
      if (occupancy1 !== 2'd2) begin errors++; $display("FAIL flush fill occ got %0d want 2", occupancy1); end
      drive1(0, 16'h0, 0, 1);
      tick();
      checks += 5;
      if (out_valid1 !== 1'b0)  begin errors++; $display("FAIL flush valid got %b want 0", out_valid1); end
      if (out_data1 !== 16'h0)  begin errors++; $display("FAIL flush data got %h want 0000", out_data1); end
      if (occupancy1 !== 2'd0)  begin errors++; $display("FAIL flush occ got %0d want 0", occupancy1); end
      if (drop_count1 !== 4'd2) begin errors++; $display("FAIL flush drop got %0d want 2", drop_count1); end
      if (in_ready1 !== 1'b1)   begin errors++; $display("FAIL flush ready got %b want 1", in_ready1); end
      drive1(1, 16'hA, 0, 0); tick();
      drive1(1, 16'hB, 0, 0); tick();
      // A leaves downstream in the flush cycle; in_ready is low while FULL so D is never accepted
      drive1(1, 16'hD, 1, 1);
      #1;
      checks += 2;
      if (out_valid1 !== 1'b1 || out_data1 !== 16'hA) begin errors++; $display("FAIL flush deliver got valid %b data %h want 1 000a", out_valid1, out_data1); end
      if (in_ready1 !== 1'b0) begin errors++; $display("FAIL flush full ready got %b want 0", in_ready1); end
      tick();
      checks += 2;
      if (drop_count1 !== 4'd3) begin errors++; $display("FAIL flush deliver drop got %0d want 3", drop_count1); end
      if (occupancy1 !== 2'd0)  begin errors++; $display("FAIL flush deliver occ got %0d want 0", occupancy1); end
      drive1(0, 16'h0, 0, 1);
      tick();
      checks += 1;
      if (drop_count1 !== 4'd3) begin errors++; $display("FAIL flush idle drop got %0d want 3", drop_count1); end
      drive1(1, 16'hE, 0, 1);
      tick();
      checks += 2;
      if (drop_count1 !== 4'd4) begin errors++; $display("FAIL flush incoming drop got %0d want 4", drop_count1); end
      if (out_valid1 !== 1'b0)  begin errors++; $display("FAIL flush incoming valid got %b want 0", out_valid1); end
      drive1(0, 16'h0, 0, 0);
   endtask

   task automatic test_skid0();
      do_reset();
      drive0(1, 16'h20, 1, 0);
      tick();
      checks += 1;
      if (out_data0 !== 16'h20 || occupancy0 !== 2'd1) begin errors++; $display("FAIL s0 load got data %h occ %0d want 0020 occ 1", out_data0, occupancy0); end
      drive0(1, 16'h21, 0, 0);
      #1;
      checks += 1;
      if (in_ready0 !== 1'b0) begin errors++; $display("FAIL s0 ready low got %b want 0", in_ready0); end
      out_ready0 = 1'b1;
      #1;
      checks += 1;
      if (in_ready0 !== 1'b1) begin errors++; $display("FAIL s0 ready high got %b want 1", in_ready0); end
      tick();
      checks += 1;
      if (out_data0 !== 16'h21) begin errors++; $display("FAIL s0 through got %h want 0021", out_data0); end
      drive0(1, 16'h22, 0, 0);
      tick();
      checks += 2;
      if (out_data0 !== 16'h21) begin errors++; $display("FAIL s0 stall data got %h want 0021", out_data0); end
      if (in_ready0 !== 1'b0)   begin errors++; $display("FAIL s0 stall ready got %b want 0", in_ready0); end
      drive0(1, 16'h23, 0, 1);
      tick();
      checks += 2;
      if (drop_count0 !== 16'd1) begin errors++; $display("FAIL s0 flush drop got %0d want 1", drop_count0); end
      if (occupancy0 !== 2'd0)   begin errors++; $display("FAIL s0 flush occ got %0d want 0", occupancy0); end
      drive0(1, 16'h24, 0, 0);
      tick();
      drive1(1, 16'h30, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      checks += 4;
      if (out_valid0 !== 1'b0)   begin errors++; $display("FAIL s0 async rst valid got %b want 0", out_valid0); end
      if (drop_count0 !== 16'd0) begin errors++; $display("FAIL s0 async rst drop got %0d want 0", drop_count0); end
      if (out_data0 !== 16'h0)   begin errors++; $display("FAIL s0 async rst data got %h want 0000", out_data0); end
      if (drop_count1 !== 4'd0)  begin errors++; $display("FAIL s1 async rst drop got %0d want 0", drop_count1); end
      drive0(0, 16'h0, 0, 0);
      drive1(0, 16'h0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] q1[$];
      logic [15:0] q0[$];
      int d1, d0, add;
      logic iv, ordy, fl, er1, er0, fi1, fo1, fi0, fo0;
      logic [15:0] dat, ed1, ed0;
      do_reset();
      d1 = 0; d0 = 0;
      for (int c = 0; c < 3000; c++) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 15) == 0);
         dat  = 16'($urandom);
         drive1(iv, dat, ordy, fl);
         drive0(iv, dat, ordy, fl);
         #1;
         er1 = (q1.size() < 2);
         er0 = (q0.size() == 0) || ordy;
         ed1 = (q1.size() > 0) ? q1[0] : 16'h0;
         ed0 = (q0.size() > 0) ? q0[0] : 16'h0;
         checks += 10;
         if (out_valid1 !== (q1.size() > 0))   begin errors++; $display("FAIL rnd valid1 cyc %0d got %b want %b", c, out_valid1, q1.size() > 0); end
         if (out_data1 !== ed1)                begin errors++; $display("FAIL rnd data1 cyc %0d got %h want %h", c, out_data1, ed1); end
         if (occupancy1 !== 2'(q1.size()))     begin errors++; $display("FAIL rnd occ1 cyc %0d got %0d want %0d", c, occupancy1, q1.size()); end
         if (in_ready1 !== er1)                begin errors++; $display("FAIL rnd ready1 cyc %0d got %b want %b", c, in_ready1, er1); end
         if (drop_count1 !== 4'(d1))           begin errors++; $display("FAIL rnd drop1 cyc %0d got %0d want %0d", c, drop_count1, d1); end
         if (out_valid0 !== (q0.size() > 0))   begin errors++; $display("FAIL rnd valid0 cyc %0d got %b want %b", c, out_valid0, q0.size() > 0); end
         if (out_data0 !== ed0)                begin errors++; $display("FAIL rnd data0 cyc %0d got %h want %h", c, out_data0, ed0); end
         if (occupancy0 !== 2'(q0.size()))     begin errors++; $display("FAIL rnd occ0 cyc %0d got %0d want %0d", c, occupancy0, q0.size()); end
         if (in_ready0 !== er0)                begin errors++; $display("FAIL rnd ready0 cyc %0d got %b want %b", c, in_ready0, er0); end
         if (drop_count0 !== 16'(d0))          begin errors++; $display("FAIL rnd drop0 cyc %0d got %0d want %0d", c, drop_count0, d0); end
         fi1 = iv && er1;  fo1 = (q1.size() > 0) && ordy;
         fi0 = iv && er0;  fo0 = (q0.size() > 0) && ordy;
         tick();
         if (fl) begin
            add = q1.size() - int'(fo1) + int'(fi1);
            d1 = (d1 + add > 15) ? 15 : d1 + add;
            q1.delete();
            add = q0.size() - int'(fo0) + int'(fi0);
            d0 = (d0 + add > 65535) ? 65535 : d0 + add;
            q0.delete();
         end else begin
            if (fo1) void'(q1.pop_front());
            if (fi1) q1.push_back(dat);
            if (fo0) void'(q0.pop_front());
            if (fi0) q0.push_back(dat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_full();
      test_skid0();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
